// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
//   Shared constants and helpers for the multi-channel timebase.
//   DEFAULT_DIV_*  : reset divisors for the game timing channels
//                    (100 MHz system clock assumed)
//   clog2_min1()   : index width that never collapses to zero bits
package tick_gen_pkg;

  // 25 MHz pixel enable for the VGA scan
  localparam int unsigned DEFAULT_DIV_VGA   = 3;
  // 40 Hz ball-motion step
  localparam int unsigned DEFAULT_DIV_BALL  = 2_500_000;
  // 4 Hz score blink (tick), 2 Hz visible square wave
  localparam int unsigned DEFAULT_DIV_BLINK = 24_999_999;

  // A single-channel build still needs a 1-bit select port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// tick_gen_chan
//   One timebase channel: divisor register, up-counter with terminal
//   compare against the divisor, registered tick pulse and toggled square.
//   Optional phase restart is built only when TICK_GEN_SYNC_EN is defined.
// Ports
//   clk     in   system clock, posedge
//   reset   in   synchronous active-high reset
//   en      in   run enable; counter holds while low
//   wr      in   load wr_div into the divisor and restart the count
//   wr_div  in   new divisor
//   sync    in   restart the count, divisor kept (TICK_GEN_SYNC_EN only)
//   tick    out  one-cycle pulse, one per div+1 enabled cycles
//   sq      out  toggles on every tick
//   div     out  current divisor
module tick_gen_chan #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 2_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
`ifdef TICK_GEN_SYNC_EN
  input  logic             sync,
`endif
  output logic             tick,
  output logic             sq,
  output logic [CNT_W-1:0] div
);

  logic [CNT_W-1:0] cnt;

  // Priority: reset, config write, sync, then normal counting. A write that
  // lands on the terminal count therefore swallows that tick and its toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      div  <= CNT_W'(DEFAULT_DIV);
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (wr) begin
      div  <= wr_div;
      cnt  <= '0;
      tick <= 1'b0;
`ifdef TICK_GEN_SYNC_EN
    end else if (sync) begin
      cnt  <= '0;
      tick <= 1'b0;
`endif
    end else if (en) begin
      // Compare for equality so an all-ones divisor stops at all-ones
      // instead of relying on wrap-around.
      if (cnt == div) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi
//   Multi-channel programmable timebase. Each channel is a tick_gen_chan;
//   this level only decodes config writes and muxes the divisor readback.
//   Optional feature macro: TICK_GEN_SYNC_EN adds the sync port, which
//   restarts every channel in phase without touching divisors or sq_out.
// Ports
//   clk      in   system clock, posedge
//   reset    in   synchronous active-high reset
//   ch_en    in   per-channel run enable
//   cfg_we   in   config write strobe
//   cfg_sel  in   channel index for write and readback
//   cfg_div  in   new divisor
//   sync     in   phase restart, all channels (TICK_GEN_SYNC_EN only)
//   tick     out  per-channel one-cycle pulse
//   sq_out   out  per-channel square output
//   div_rd   out  divisor of channel cfg_sel, 0 when cfg_sel is out of range
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_BALL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic                          cfg_we,
  input  logic [clog2_min1(NUM_CH)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]              cfg_div,
`ifdef TICK_GEN_SYNC_EN
  input  logic                          sync,
`endif
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             sq_out,
  output logic [CNT_W-1:0]              div_rd
);

  logic [NUM_CH-1:0] wr_vec;
  logic [CNT_W-1:0]  div_arr [NUM_CH];

  // An out-of-range cfg_sel matches no channel, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_vec[i] = cfg_we && (int'(cfg_sel) == i);

    tick_gen_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (ch_en[i]),
      .wr     (wr_vec[i]),
      .wr_div (cfg_div),
`ifdef TICK_GEN_SYNC_EN
      .sync   (sync),
`endif
      .tick   (tick[i]),
      .sq     (sq_out[i]),
      .div    (div_arr[i])
    );
  end

  always_comb begin
    div_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_sel) == i) div_rd = div_arr[i];
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

  localparam int K_TICK  = 0;
  localparam int K_SQ    = 1;
  localparam int K_DIV   = 2;
  localparam int K_TICK3 = 3;
  localparam int K_DIV3  = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] mask;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ch_en;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_div;
  logic       sync;
  logic [3:0] tick;
  logic [3:0] sq_out;
  logic [7:0] div_rd;

  // Second instance with a non-power-of-two channel count so that an
  // out-of-range select is expressible on the 2-bit cfg_sel.
  logic [2:0] ch_en3;
  logic       cfg_we3;
  logic [1:0] cfg_sel3;
  logic [7:0] cfg_div3;
  logic       sync3;
  logic [2:0] tick3;
  logic [2:0] sq_out3;
  logic [7:0] div_rd3;

  int   cyc = 0;
  int   t0  = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_gen_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .ch_en   (ch_en),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_div (cfg_div),
`ifdef TICK_GEN_SYNC_EN
    .sync    (sync),
`endif
    .tick    (tick),
    .sq_out  (sq_out),
    .div_rd  (div_rd)
  );

  tick_gen_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .ch_en   (ch_en3),
    .cfg_we  (cfg_we3),
    .cfg_sel (cfg_sel3),
    .cfg_div (cfg_div3),
`ifdef TICK_GEN_SYNC_EN
    .sync    (sync3),
`endif
    .tick    (tick3),
    .sq_out  (sq_out3),
    .div_rd  (div_rd3)
  );

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_TICK:  return {28'd0, tick};
      K_SQ:    return {28'd0, sq_out};
      K_DIV:   return {24'd0, div_rd};
      K_TICK3: return {29'd0, tick3};
      default: return {24'd0, div_rd3};
    endcase
  endfunction

  // Monitor: on every falling edge, retire the expectations due this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        logic [31:0] got;
        got = actual(sb_q[i].kind) & sb_q[i].mask;
        n_vec++;
        if (got !== sb_q[i].val) begin
          n_err++;
          $display("FAIL %s @t0+%0d: got 0x%0h expected 0x%0h",
                   sb_q[i].name, cyc - t0, got, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input int kind, input logic [31:0] mask,
                           input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = t0 + off;
    e.kind = kind;
    e.mask = mask;
    e.val  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic step_to(input int off);
    while (cyc < t0 + off) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; ch_en = 4'h0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_div = 8'd0; sync = 1'b0;
    ch_en3 = 3'b000; cfg_we3 = 1'b0; cfg_sel3 = 2'd0; cfg_div3 = 8'd0; sync3 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    t0 = cyc;

    n_vec++;
    if (tick !== 4'h0) begin
      n_err++;
      $display("FAIL direct_reset_tick: got 0x%0h expected 0x0", tick);
    end
    n_vec++;
    if (sq_out !== 4'h0) begin
      n_err++;
      $display("FAIL direct_reset_sq: got 0x%0h expected 0x0", sq_out);
    end
    n_vec++;
    if (div_rd !== 8'd3) begin
      n_err++;
      $display("FAIL direct_reset_div_rd: got 0x%0h expected 0x3", div_rd);
    end
    n_vec++;
    if (div_rd3 !== 8'd3) begin
      n_err++;
      $display("FAIL direct_reset_div_rd3: got 0x%0h expected 0x3", div_rd3);
    end

    // Reset state
    expect_at(0, K_TICK, 32'hF, 32'h0, "reset_tick");
    expect_at(0, K_SQ,   32'hF, 32'h0, "reset_sq");
    expect_at(0, K_DIV,  32'hFF, 32'd3, "reset_div_rd");
    expect_at(0, K_DIV3, 32'hFF, 32'd3, "reset_div_rd3");

    // 1: default divisor 3, all channels run: tick every 4, sq period 8
    reset = 1'b0; ch_en = 4'hF; ch_en3 = 3'b111;
    expect_at(1, K_TICK, 32'hF, 32'h0, "t1_tick_c1");
    expect_at(3, K_TICK, 32'hF, 32'h0, "t1_tick_c3");
    expect_at(4, K_TICK, 32'hF, 32'hF, "t1_tick_c4");
    expect_at(4, K_SQ,   32'hF, 32'hF, "t1_sq_c4");
    expect_at(5, K_TICK, 32'hF, 32'h0, "t1_tick_c5");
    expect_at(7, K_SQ,   32'hF, 32'hF, "t1_sq_c7");
    expect_at(8, K_TICK, 32'hF, 32'hF, "t1_tick_c8");
    expect_at(8, K_SQ,   32'hF, 32'h0, "t1_sq_c8");
    step_to(8);

    // 2: divisor 0 on channel 2 -> continuous tick from 2nd cycle after write
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_div = 8'd0;
    expect_at(9,  K_TICK, 32'hF, 32'h0, "t2_tick_c9");
    expect_at(9,  K_SQ,   32'hF, 32'h0, "t2_sq_c9");
    expect_at(10, K_TICK, 32'hF, 32'h4, "t2_tick_c10");
    expect_at(10, K_SQ,   32'hF, 32'h4, "t2_sq_c10");
    expect_at(10, K_DIV,  32'hFF, 32'd0, "t2_div_rd");
    expect_at(11, K_TICK, 32'hF, 32'h4, "t2_tick_c11");
    expect_at(11, K_SQ,   32'hF, 32'h0, "t2_sq_c11");
    expect_at(12, K_TICK, 32'hF, 32'hF, "t2_tick_c12");
    expect_at(12, K_SQ,   32'hF, 32'hF, "t2_sq_c12");
    step_to(9);
    cfg_we = 1'b0;
    step_to(15);

    // 3: write div 5 to channel 1 exactly at its terminal count
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd5;
    expect_at(16, K_TICK, 32'h2, 32'h0, "t3_no_tick");
    expect_at(16, K_TICK, 32'h9, 32'h9, "t3_others_tick");
    expect_at(16, K_SQ,   32'h2, 32'h2, "t3_sq_held");
    expect_at(16, K_DIV,  32'hFF, 32'd5, "t3_div_rd");
    expect_at(21, K_TICK, 32'h2, 32'h0, "t3_tick_c21");
    expect_at(22, K_TICK, 32'h2, 32'h2, "t3_tick_c22");
    expect_at(22, K_SQ,   32'h2, 32'h0, "t3_sq_c22");
    expect_at(23, K_TICK, 32'h2, 32'h0, "t3_tick_c23");
    step_to(16);
    cfg_we = 1'b0;
    step_to(21);

    // 4: disable channel 0 for 10 cycles with cnt=1
    ch_en = 4'hE;
    expect_at(22, K_TICK, 32'h1, 32'h0, "t4_tick_off_c22");
    expect_at(25, K_SQ,   32'h1, 32'h1, "t4_sq_frozen_c25");
    expect_at(27, K_TICK, 32'h1, 32'h0, "t4_tick_off_c27");
    expect_at(28, K_TICK, 32'h8, 32'h8, "t4_ch3_indep");
    expect_at(31, K_TICK, 32'h1, 32'h0, "t4_tick_off_c31");
    expect_at(33, K_TICK, 32'h1, 32'h0, "t4_tick_c33");
    expect_at(33, K_SQ,   32'h1, 32'h1, "t4_sq_c33");
    expect_at(34, K_TICK, 32'h1, 32'h1, "t4_tick_c34");
    expect_at(34, K_SQ,   32'h1, 32'h0, "t4_sq_c34");
    step_to(31);
    ch_en = 4'hF;
    step_to(34);

    // 5: div[3]=9 then reset mid-period
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_div = 8'd9;
    expect_at(36, K_DIV, 32'hFF, 32'd9, "t5_div_rd_pre");
    expect_at(39, K_TICK, 32'hF, 32'h0, "t5_reset_tick");
    expect_at(39, K_SQ,   32'hF, 32'h0, "t5_reset_sq");
    expect_at(39, K_DIV,  32'hFF, 32'd3, "t5_reset_div_rd");
    expect_at(43, K_TICK, 32'hF, 32'hF, "t5_restart_tick");
    step_to(35);
    cfg_we = 1'b0;
    step_to(38);
    reset = 1'b1;
    step_to(39);
    reset = 1'b0;
    step_to(41);

    // Out-of-range select on the 3-channel instance is ignored
    cfg_we3 = 1'b1; cfg_sel3 = 2'd3; cfg_div3 = 8'd0;
    expect_at(42, K_DIV3,  32'hFF, 32'd0, "oor_div_rd");
    expect_at(43, K_TICK3, 32'h7, 32'h7, "oor_tick3");
    step_to(42);
    cfg_we3 = 1'b0;
    step_to(43);
    cfg_sel3 = 2'd0;
    expect_at(43, K_DIV3, 32'hFF, 32'd3, "oor_div_rd_sel0");
    step_to(44);

    // Divisors 3/5/7/3
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_div = 8'd5;
    expect_at(50, K_TICK, 32'h2, 32'h0, "t6_ch1_c50");
    expect_at(51, K_TICK, 32'h2, 32'h2, "t6_ch1_c51");
    step_to(45);
    cfg_sel = 2'd2; cfg_div = 8'd7;
    step_to(46);
    cfg_we = 1'b0;

`ifdef TICK_GEN_SYNC_EN
    // 6: sync pulse; first tick per channel at div+1 cycles after it
    step_to(55);
    sync = 1'b1;
    expect_at(56, K_TICK, 32'hF, 32'h0, "t6_sync_c56");
    expect_at(59, K_TICK, 32'hF, 32'h0, "t6_sync_c59");
    expect_at(60, K_TICK, 32'hF, 32'h9, "t6_sync_c60");
    expect_at(61, K_TICK, 32'hF, 32'h0, "t6_sync_c61");
    expect_at(62, K_TICK, 32'hF, 32'h2, "t6_sync_c62");
    expect_at(63, K_TICK, 32'hF, 32'h0, "t6_sync_c63");
    expect_at(64, K_TICK, 32'hF, 32'hD, "t6_sync_c64");
    step_to(56);
    sync = 1'b0;
`endif

    step_to(66);
    foreach (sb_q[i]) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: never checked, expected 0x%0h", sb_q[i].name, sb_q[i].val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
